// File: rtl/axi_lite_rr_arbiter_if.sv
// AXI4-Lite bundle shared by the arbiter's upstream and downstream ports.
// Master drives requests and response readies; Slave is the mirror view.
interface axi_lite_rr_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]            aw_prot;
  logic                  aw_valid;
  logic                  aw_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  w_valid;
  logic                  w_ready;
  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]            ar_prot;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_valid;
  logic                  r_ready;

  modport Master (
    output aw_addr, aw_prot, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input  b_resp, b_valid, output b_ready,
    output ar_addr, ar_prot, ar_valid, input ar_ready,
    input  r_data, r_resp, r_valid, output r_ready
  );

  modport Slave (
    input  aw_addr, aw_prot, aw_valid, output aw_ready,
    input  w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input  ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );
endinterface

// File: rtl/axi_lite_rr_arbiter.sv
// Round-robin N-to-1 AXI4-Lite arbiter: one transaction in flight at a time,
// granted master's channels are muxed combinationally onto the downstream port.
module axi_lite_rr_arbiter #(
  parameter int unsigned NUM_MST        = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  localparam int unsigned SEL_W         = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  axi_lite_rr_arbiter_if.Slave        mst [NUM_MST],
  axi_lite_rr_arbiter_if.Master       slv,
  output logic [SEL_W-1:0]            sel_o,
  output logic                        busy_o
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned CW     = SEL_W + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_RESP = 3'd2,
    WR      = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t             state_q;
  logic [SEL_W-1:0]   rr_ptr_q;
  logic [SEL_W-1:0]   sel_q;
  logic               last_rd_q;
  logic               aw_done_q;
  logic               w_done_q;
  logic               busy_q;

  // Upstream signals flattened so they can be indexed by the grant register.
  logic [NUM_MST-1:0]        m_ar_valid;
  logic [NUM_MST-1:0]        m_aw_valid;
  logic [NUM_MST-1:0]        m_w_valid;
  logic [NUM_MST-1:0]        m_r_ready;
  logic [NUM_MST-1:0]        m_b_ready;
  logic [AXI_ADDR_WIDTH-1:0] m_ar_addr [NUM_MST];
  logic [AXI_ADDR_WIDTH-1:0] m_aw_addr [NUM_MST];
  logic [2:0]                m_ar_prot [NUM_MST];
  logic [2:0]                m_aw_prot [NUM_MST];
  logic [AXI_DATA_WIDTH-1:0] m_w_data  [NUM_MST];
  logic [STRB_W-1:0]         m_w_strb  [NUM_MST];
  logic [NUM_MST-1:0]        req;
  logic [NUM_MST-1:0]        gnt_oh;

  logic in_rd_addr, in_rd_resp, in_wr, in_wr_resp;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign in_rd_addr = (state_q == RD_ADDR);
  assign in_rd_resp = (state_q == RD_RESP);
  assign in_wr      = (state_q == WR);
  assign in_wr_resp = (state_q == WR_RESP);

  for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_mst
    assign m_ar_valid[gi] = mst[gi].ar_valid;
    assign m_aw_valid[gi] = mst[gi].aw_valid;
    assign m_w_valid[gi]  = mst[gi].w_valid;
    assign m_r_ready[gi]  = mst[gi].r_ready;
    assign m_b_ready[gi]  = mst[gi].b_ready;
    assign m_ar_addr[gi]  = mst[gi].ar_addr;
    assign m_aw_addr[gi]  = mst[gi].aw_addr;
    assign m_ar_prot[gi]  = mst[gi].ar_prot;
    assign m_aw_prot[gi]  = mst[gi].aw_prot;
    assign m_w_data[gi]   = mst[gi].w_data;
    assign m_w_strb[gi]   = mst[gi].w_strb;
    assign req[gi]        = mst[gi].ar_valid | mst[gi].aw_valid;
    assign gnt_oh[gi]     = (sel_q == SEL_W'(gi));

    // Only the granted master ever sees a ready or a response valid.
    assign mst[gi].ar_ready = in_rd_addr & gnt_oh[gi] & slv.ar_ready;
    assign mst[gi].aw_ready = in_wr & ~aw_done_q & gnt_oh[gi] & slv.aw_ready;
    assign mst[gi].w_ready  = in_wr & ~w_done_q & gnt_oh[gi] & slv.w_ready;
    assign mst[gi].r_valid  = in_rd_resp & gnt_oh[gi] & slv.r_valid;
    assign mst[gi].r_data   = slv.r_data;
    assign mst[gi].r_resp   = slv.r_resp;
    assign mst[gi].b_valid  = in_wr_resp & gnt_oh[gi] & slv.b_valid;
    assign mst[gi].b_resp   = slv.b_resp;
  end

  assign slv.ar_valid = in_rd_addr & m_ar_valid[sel_q];
  assign slv.ar_addr  = m_ar_addr[sel_q];
  assign slv.ar_prot  = m_ar_prot[sel_q];
  assign slv.aw_valid = in_wr & ~aw_done_q & m_aw_valid[sel_q];
  assign slv.aw_addr  = m_aw_addr[sel_q];
  assign slv.aw_prot  = m_aw_prot[sel_q];
  assign slv.w_valid  = in_wr & ~w_done_q & m_w_valid[sel_q];
  assign slv.w_data   = m_w_data[sel_q];
  assign slv.w_strb   = m_w_strb[sel_q];
  assign slv.r_ready  = in_rd_resp & m_r_ready[sel_q];
  assign slv.b_ready  = in_wr_resp & m_b_ready[sel_q];

  assign ar_hs = slv.ar_valid & slv.ar_ready;
  assign r_hs  = slv.r_ready  & slv.r_valid;
  assign aw_hs = slv.aw_valid & slv.aw_ready;
  assign w_hs  = slv.w_valid  & slv.w_ready;
  assign b_hs  = slv.b_ready  & slv.b_valid;

  // Round-robin search starting at rr_ptr; the wrap is explicit so that
  // non-power-of-two master counts never produce an out-of-range index.
  logic             grant_found;
  logic [SEL_W-1:0] sel_d;
  logic [CW-1:0]    cand;
  logic             pick_rd;
  logic [SEL_W-1:0] rr_ptr_d;

  always_comb begin
    grant_found = 1'b0;
    sel_d       = '0;
    cand        = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      cand = {1'b0, rr_ptr_q} + CW'(i);
      if (cand >= CW'(NUM_MST)) begin
        cand = cand - CW'(NUM_MST);
      end
      if (!grant_found && req[cand[SEL_W-1:0]]) begin
        grant_found = 1'b1;
        sel_d       = cand[SEL_W-1:0];
      end
    end
  end

  // A master holding both AR and AW alternates, starting with the read.
  assign pick_rd  = m_ar_valid[sel_d] & (~m_aw_valid[sel_d] | ~last_rd_q);
  assign rr_ptr_d = (sel_q == SEL_W'(NUM_MST - 1)) ? '0 : sel_q + SEL_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      sel_q     <= '0;
      last_rd_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            sel_q     <= sel_d;
            last_rd_q <= pick_rd;
            busy_q    <= 1'b1;
            state_q   <= pick_rd ? RD_ADDR : WR;
          end
        end
        RD_ADDR: begin
          if (ar_hs) begin
            state_q <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (r_hs) begin
            state_q  <= IDLE;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= '0;
            busy_q   <= 1'b0;
          end
        end
        WR: begin
          if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
            state_q   <= WR_RESP;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            state_q  <= IDLE;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= '0;
            busy_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel_o  = sel_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Scoreboard bench for axi_lite_rr_arbiter: a 4-master instance driven by tasks
// and a free-running 3-master instance used to observe pointer wrap.
module tb_axi_lite_rr_arbiter;

  typedef struct {
    int          m;
    bit          rd;
    logic [63:0] addr;
    logic [63:0] data;
    logic [1:0]  resp;
  } txn_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  txn_t exp_q[$];
  int   rd_left[4];

  logic        m_ar_valid[4], m_aw_valid[4], m_w_valid[4], m_r_ready[4], m_b_ready[4];
  logic [63:0] m_ar_addr[4], m_aw_addr[4], m_w_data[4];
  logic        m_ar_ready[4], m_aw_ready[4], m_w_ready[4], m_r_valid[4], m_b_valid[4];
  logic [63:0] m_r_data[4];
  logic [1:0]  m_r_resp[4], m_b_resp[4];

  logic [1:0]  sel_o, sel3_o;
  logic        busy_o, busy3_o;

  axi_lite_rr_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) mst_if [4] ();
  axi_lite_rr_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) slv_if ();
  axi_lite_rr_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) mst3_if [3] ();
  axi_lite_rr_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) slv3_if ();

  axi_lite_rr_arbiter #(.NUM_MST(4), .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64)) dut (
    .clk_i (clk), .rst_i (rst), .mst (mst_if), .slv (slv_if), .sel_o (sel_o), .busy_o (busy_o)
  );

  axi_lite_rr_arbiter #(.NUM_MST(3), .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64)) dut3 (
    .clk_i (clk), .rst_i (rst), .mst (mst3_if), .slv (slv3_if), .sel_o (sel3_o), .busy_o (busy3_o)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_m
    assign mst_if[gi].ar_valid = m_ar_valid[gi];
    assign mst_if[gi].ar_addr  = m_ar_addr[gi];
    assign mst_if[gi].ar_prot  = 3'b000;
    assign mst_if[gi].aw_valid = m_aw_valid[gi];
    assign mst_if[gi].aw_addr  = m_aw_addr[gi];
    assign mst_if[gi].aw_prot  = 3'b000;
    assign mst_if[gi].w_valid  = m_w_valid[gi];
    assign mst_if[gi].w_data   = m_w_data[gi];
    assign mst_if[gi].w_strb   = 8'hFF;
    assign mst_if[gi].r_ready  = m_r_ready[gi];
    assign mst_if[gi].b_ready  = m_b_ready[gi];
    assign m_ar_ready[gi] = mst_if[gi].ar_ready;
    assign m_aw_ready[gi] = mst_if[gi].aw_ready;
    assign m_w_ready[gi]  = mst_if[gi].w_ready;
    assign m_r_valid[gi]  = mst_if[gi].r_valid;
    assign m_r_data[gi]   = mst_if[gi].r_data;
    assign m_r_resp[gi]   = mst_if[gi].r_resp;
    assign m_b_valid[gi]  = mst_if[gi].b_valid;
    assign m_b_resp[gi]   = mst_if[gi].b_resp;
  end

  // Masters 1 and 2 of the 3-master instance read continuously; the slave is always ready.
  for (genvar gi = 0; gi < 3; gi++) begin : g_m3
    assign mst3_if[gi].ar_valid = (gi != 0);
    assign mst3_if[gi].ar_addr  = 64'(gi);
    assign mst3_if[gi].ar_prot  = 3'b000;
    assign mst3_if[gi].aw_valid = 1'b0;
    assign mst3_if[gi].aw_addr  = '0;
    assign mst3_if[gi].aw_prot  = 3'b000;
    assign mst3_if[gi].w_valid  = 1'b0;
    assign mst3_if[gi].w_data   = '0;
    assign mst3_if[gi].w_strb   = '0;
    assign mst3_if[gi].r_ready  = 1'b1;
    assign mst3_if[gi].b_ready  = 1'b1;
  end
  assign slv3_if.ar_ready = 1'b1;
  assign slv3_if.r_valid  = 1'b1;
  assign slv3_if.r_data   = '0;
  assign slv3_if.r_resp   = 2'b00;
  assign slv3_if.aw_ready = 1'b0;
  assign slv3_if.w_ready  = 1'b0;
  assign slv3_if.b_valid  = 1'b0;
  assign slv3_if.b_resp   = 2'b00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  a_ar_hold: assert property (@(posedge clk) disable iff (rst)
    (slv_if.ar_valid && !slv_if.ar_ready) |=> slv_if.ar_valid)
    else begin n_bad++; $display("FAIL ar_valid_hold: downstream ar_valid dropped before handshake"); end
  a_aw_hold: assert property (@(posedge clk) disable iff (rst)
    (slv_if.aw_valid && !slv_if.aw_ready) |=> slv_if.aw_valid)
    else begin n_bad++; $display("FAIL aw_valid_hold: downstream aw_valid dropped before handshake"); end

  function automatic int cnt4(input logic v[4]);
    int c = 0;
    for (int i = 0; i < 4; i++) if (v[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic clear_drives();
    for (int i = 0; i < 4; i++) begin
      m_ar_valid[i] = 1'b0; m_aw_valid[i] = 1'b0; m_w_valid[i] = 1'b0;
      m_r_ready[i]  = 1'b1; m_b_ready[i]  = 1'b1;
      m_ar_addr[i]  = '0;   m_aw_addr[i]  = '0;   m_w_data[i] = '0;
      rd_left[i]    = 0;
    end
    slv_if.ar_ready = 1'b0; slv_if.aw_ready = 1'b0; slv_if.w_ready = 1'b0;
    slv_if.r_valid  = 1'b0; slv_if.r_data   = '0;   slv_if.r_resp  = 2'b00;
    slv_if.b_valid  = 1'b0; slv_if.b_resp   = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_drives();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic serve_read(input int ar_lat, output int waited);
    txn_t e;
    int   n;
    waited = -1;
    for (n = 0; n < 40; n++) begin
      @(negedge clk); #1;
      if (slv_if.ar_valid === 1'b1) break;
    end
    n_vec++;
    if (slv_if.ar_valid !== 1'b1) begin
      n_bad++; $display("FAIL rd_timeout: ar_valid=%b after 40 cycles, required 1", slv_if.ar_valid);
      return;
    end
    waited = n;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++; $display("FAIL rd_unexpected: ar_addr=%h with empty scoreboard", slv_if.ar_addr);
      return;
    end
    e = exp_q.pop_front();
    if (e.rd !== 1'b1) begin n_bad++; $display("FAIL rd_kind: got read, required write to %h", e.addr); end
    n_vec++;
    if (slv_if.ar_addr !== e.addr) begin n_bad++; $display("FAIL rd_addr: got %h required %h", slv_if.ar_addr, e.addr); end
    n_vec++;
    if (sel_o !== 2'(e.m) || busy_o !== 1'b1) begin
      n_bad++; $display("FAIL rd_sel: sel_o=%0d busy_o=%b required sel_o=%0d busy_o=1", sel_o, busy_o, e.m);
    end
    n_vec++;
    if (cnt4(m_aw_ready) != 0 || cnt4(m_w_ready) != 0 || slv_if.aw_valid !== 1'b0) begin
      n_bad++; $display("FAIL rd_no_write: aw_ready#=%0d w_ready#=%0d slv_aw_valid=%b required 0/0/0",
                        cnt4(m_aw_ready), cnt4(m_w_ready), slv_if.aw_valid);
    end
    repeat (ar_lat) @(negedge clk);
    slv_if.ar_ready = 1'b1; #1;
    n_vec++;
    if (m_ar_ready[e.m] !== 1'b1 || cnt4(m_ar_ready) != 1) begin
      n_bad++; $display("FAIL rd_ar_ready: mst%0d ar_ready=%b total=%0d required 1/1", e.m, m_ar_ready[e.m], cnt4(m_ar_ready));
    end
    @(negedge clk);
    slv_if.ar_ready = 1'b0;
    rd_left[e.m]--;
    if (rd_left[e.m] <= 0) m_ar_valid[e.m] = 1'b0;
    slv_if.r_valid = 1'b1; slv_if.r_data = e.data; slv_if.r_resp = e.resp; #1;
    n_vec++;
    if (m_r_valid[e.m] !== 1'b1 || cnt4(m_r_valid) != 1 || m_r_data[e.m] !== e.data || m_r_resp[e.m] !== e.resp) begin
      n_bad++; $display("FAIL rd_resp: mst%0d r_valid=%b total=%0d data=%h resp=%b required 1/1/%h/%b",
                        e.m, m_r_valid[e.m], cnt4(m_r_valid), m_r_data[e.m], m_r_resp[e.m], e.data, e.resp);
    end
    @(negedge clk);
    slv_if.r_valid = 1'b0; #1;
    n_vec++;
    if (busy_o !== 1'b0 || sel_o !== 2'd0 || slv_if.ar_valid !== 1'b0) begin
      n_bad++; $display("FAIL rd_idle: busy_o=%b sel_o=%0d ar_valid=%b required 0/0/0", busy_o, sel_o, slv_if.ar_valid);
    end
    $display("read  mst%0d addr=%h data=%h resp=%b waited=%0d", e.m, e.addr, e.data, e.resp, waited);
  endtask

  // mode 0: slave takes AW and W together; mode 1: W first, AW one cycle later.
  task automatic serve_write(input int mode);
    txn_t e;
    int   n;
    for (n = 0; n < 40; n++) begin
      @(negedge clk); #1;
      if (slv_if.aw_valid === 1'b1) break;
    end
    n_vec++;
    if (slv_if.aw_valid !== 1'b1) begin
      n_bad++; $display("FAIL wr_timeout: aw_valid=%b after 40 cycles, required 1", slv_if.aw_valid);
      return;
    end
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++; $display("FAIL wr_unexpected: aw_addr=%h with empty scoreboard", slv_if.aw_addr);
      return;
    end
    e = exp_q.pop_front();
    if (e.rd !== 1'b0) begin n_bad++; $display("FAIL wr_kind: got write, required read from %h", e.addr); end
    n_vec++;
    if (slv_if.aw_addr !== e.addr || slv_if.w_valid !== 1'b1 || slv_if.w_data !== e.data) begin
      n_bad++; $display("FAIL wr_payload: aw_addr=%h w_valid=%b w_data=%h required %h/1/%h",
                        slv_if.aw_addr, slv_if.w_valid, slv_if.w_data, e.addr, e.data);
    end
    n_vec++;
    if (sel_o !== 2'(e.m) || busy_o !== 1'b1) begin
      n_bad++; $display("FAIL wr_sel: sel_o=%0d busy_o=%b required %0d/1", sel_o, busy_o, e.m);
    end
    if (mode == 0) begin
      slv_if.aw_ready = 1'b1; slv_if.w_ready = 1'b1; #1;
      n_vec++;
      if (m_aw_ready[e.m] !== 1'b1 || m_w_ready[e.m] !== 1'b1) begin
        n_bad++; $display("FAIL wr_readies: aw_ready=%b w_ready=%b required 1/1", m_aw_ready[e.m], m_w_ready[e.m]);
      end
      @(negedge clk);
      slv_if.aw_ready = 1'b0; slv_if.w_ready = 1'b0;
      m_aw_valid[e.m] = 1'b0; m_w_valid[e.m] = 1'b0;
    end else begin
      slv_if.w_ready = 1'b1; #1;
      n_vec++;
      if (m_w_ready[e.m] !== 1'b1 || m_aw_ready[e.m] !== 1'b0) begin
        n_bad++; $display("FAIL wr_w_first: w_ready=%b aw_ready=%b required 1/0", m_w_ready[e.m], m_aw_ready[e.m]);
      end
      @(negedge clk);
      slv_if.w_ready = 1'b0; m_w_valid[e.m] = 1'b0; #1;
      n_vec++;
      if (slv_if.w_valid !== 1'b0 || slv_if.aw_valid !== 1'b1 || slv_if.b_ready !== 1'b0) begin
        n_bad++; $display("FAIL wr_half_done: w_valid=%b aw_valid=%b b_ready=%b required 0/1/0",
                          slv_if.w_valid, slv_if.aw_valid, slv_if.b_ready);
      end
      slv_if.aw_ready = 1'b1;
      @(negedge clk);
      slv_if.aw_ready = 1'b0; m_aw_valid[e.m] = 1'b0;
    end
    #1;
    n_vec++;
    if (slv_if.b_ready !== 1'b1 || slv_if.aw_valid !== 1'b0 || slv_if.w_valid !== 1'b0) begin
      n_bad++; $display("FAIL wr_resp_entry: b_ready=%b aw_valid=%b w_valid=%b required 1/0/0",
                        slv_if.b_ready, slv_if.aw_valid, slv_if.w_valid);
    end
    slv_if.b_valid = 1'b1; slv_if.b_resp = e.resp; #1;
    n_vec++;
    if (m_b_valid[e.m] !== 1'b1 || cnt4(m_b_valid) != 1 || m_b_resp[e.m] !== e.resp) begin
      n_bad++; $display("FAIL wr_bresp: mst%0d b_valid=%b total=%0d b_resp=%b required 1/1/%b",
                        e.m, m_b_valid[e.m], cnt4(m_b_valid), m_b_resp[e.m], e.resp);
    end
    @(negedge clk);
    slv_if.b_valid = 1'b0; #1;
    n_vec++;
    if (busy_o !== 1'b0 || sel_o !== 2'd0) begin
      n_bad++; $display("FAIL wr_idle: busy_o=%b sel_o=%0d required 0/0", busy_o, sel_o);
    end
    $display("write mst%0d addr=%h data=%h bresp=%b mode=%0d", e.m, e.addr, e.data, e.resp, mode);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_drives();
    for (int i = 0; i < 4; i++) begin m_ar_valid[i] = 1'b1; m_aw_valid[i] = 1'b1; end
    repeat (3) @(negedge clk); #1;
    n_vec++;
    if (busy_o !== 1'b0 || sel_o !== 2'd0 || busy3_o !== 1'b0 || sel3_o !== 2'd0) begin
      n_bad++; $display("FAIL reset_status: busy_o=%b sel_o=%0d busy3=%b sel3=%0d required all 0", busy_o, sel_o, busy3_o, sel3_o);
    end
    n_vec++;
    if ({slv_if.ar_valid, slv_if.aw_valid, slv_if.w_valid, slv_if.r_ready, slv_if.b_ready} !== 5'b0) begin
      n_bad++; $display("FAIL reset_slv: ar/aw/w valid, r/b ready = %b required 00000",
                        {slv_if.ar_valid, slv_if.aw_valid, slv_if.w_valid, slv_if.r_ready, slv_if.b_ready});
    end
    n_vec++;
    if (cnt4(m_ar_ready) + cnt4(m_aw_ready) + cnt4(m_w_ready) + cnt4(m_r_valid) + cnt4(m_b_valid) != 0) begin
      n_bad++; $display("FAIL reset_mst: %0d master ready/valid bits set, required 0",
                        cnt4(m_ar_ready) + cnt4(m_aw_ready) + cnt4(m_w_ready) + cnt4(m_r_valid) + cnt4(m_b_valid));
    end
    $display("reset checked");
    do_reset();
  endtask

  task automatic test_wrap();
    int exp_m[$];
    int want;
    int seen = 0;
    do_reset();
    exp_m = '{1, 2, 1, 2};
    for (int c = 0; c < 40 && exp_m.size() > 0; c++) begin
      @(negedge clk); #1;
      n_vec++;
      if (sel3_o > 2'd2) begin n_bad++; $display("FAIL wrap_sel_range: sel3_o=%0d required <= 2", sel3_o); end
      if (slv3_if.ar_valid === 1'b1) begin
        want = exp_m.pop_front();
        n_vec++;
        if (slv3_if.ar_addr !== 64'(want) || sel3_o !== 2'(want)) begin
          n_bad++; $display("FAIL wrap_order: grant %0d (sel3_o=%0d) required %0d", slv3_if.ar_addr, sel3_o, want);
        end
        seen++;
        $display("wrap  grant #%0d -> mst%0d", seen, slv3_if.ar_addr);
      end
    end
    n_vec++;
    if (seen != 4) begin n_bad++; $display("FAIL wrap_count: saw %0d grants, required 4", seen); end
  endtask

  task automatic test_single_read();
    int w;
    do_reset();
    m_ar_valid[2] = 1'b1; m_ar_addr[2] = 64'h1000; rd_left[2] = 1;
    exp_q.push_back('{m: 2, rd: 1'b1, addr: 64'h1000, data: 64'hDEAD, resp: 2'b00});
    serve_read(2, w);
  endtask

  task automatic test_back_to_back();
    int order[6] = '{0, 1, 2, 3, 0, 1};
    int w;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m_ar_valid[i] = 1'b1; m_ar_addr[i] = 64'h100 * (i + 1);
      rd_left[i] = (i < 2) ? 2 : 1;
    end
    for (int k = 0; k < 6; k++)
      exp_q.push_back('{m: order[k], rd: 1'b1, addr: 64'h100 * (order[k] + 1), data: 64'hA000 + 64'(k), resp: 2'b00});
    for (int k = 0; k < 6; k++) begin
      serve_read(0, w);
      if (k > 0) begin
        n_vec++;
        if (w != 0) begin n_bad++; $display("FAIL b2b_gap: txn %0d waited %0d extra cycles, required 0", k, w); end
      end
    end
  endtask

  task automatic test_rd_wr_same_master();
    int w;
    do_reset();
    m_ar_valid[1] = 1'b1; m_ar_addr[1] = 64'h3000; rd_left[1] = 1;
    m_aw_valid[1] = 1'b1; m_aw_addr[1] = 64'h3008;
    m_w_valid[1]  = 1'b1; m_w_data[1]  = 64'h1234;
    exp_q.push_back('{m: 1, rd: 1'b1, addr: 64'h3000, data: 64'hBEEF, resp: 2'b00});
    exp_q.push_back('{m: 1, rd: 1'b0, addr: 64'h3008, data: 64'h1234, resp: 2'b00});
    serve_read(0, w);
    serve_write(0);
    n_vec++;
    if (dut.last_rd_q !== 1'b0) begin n_bad++; $display("FAIL last_rd: got %b required 0", dut.last_rd_q); end
  endtask

  task automatic test_w_before_aw();
    m_w_valid[0] = 1'b1; m_w_data[0] = 64'h5555;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_vec++;
      if (busy_o !== 1'b0 || slv_if.w_valid !== 1'b0) begin
        n_bad++; $display("FAIL w_only_idle: busy_o=%b w_valid=%b required 0/0", busy_o, slv_if.w_valid);
      end
    end
    m_aw_valid[0] = 1'b1; m_aw_addr[0] = 64'h4000;
    exp_q.push_back('{m: 0, rd: 1'b0, addr: 64'h4000, data: 64'h5555, resp: 2'b10});
    serve_write(1);
  endtask

  task automatic test_reset_mid_read();
    int w;
    int n;
    m_ar_valid[2] = 1'b1; m_ar_addr[2] = 64'h2222;
    for (n = 0; n < 40; n++) begin
      @(negedge clk); #1;
      if (slv_if.ar_valid === 1'b1) break;
    end
    slv_if.ar_ready = 1'b1;
    @(negedge clk);
    slv_if.ar_ready = 1'b0; m_ar_valid[2] = 1'b0;
    slv_if.r_valid = 1'b1; slv_if.r_data = 64'h77; #1;
    n_vec++;
    if (m_r_valid[2] !== 1'b1) begin n_bad++; $display("FAIL abort_setup: mst2 r_valid=%b required 1", m_r_valid[2]); end
    rst = 1'b1; #1;
    n_vec++;
    if (busy_o !== 1'b0 || sel_o !== 2'd0 || cnt4(m_r_valid) != 0 || slv_if.r_ready !== 1'b0 ||
        slv_if.ar_valid !== 1'b0 || cnt4(m_ar_ready) != 0) begin
      n_bad++; $display("FAIL abort_outputs: busy=%b sel=%0d r_valid#=%0d r_ready=%b ar_valid=%b ar_ready#=%0d required all 0",
                        busy_o, sel_o, cnt4(m_r_valid), slv_if.r_ready, slv_if.ar_valid, cnt4(m_ar_ready));
    end
    $display("reset during RD_RESP checked");
    do_reset();
    m_ar_valid[0] = 1'b1; m_ar_addr[0] = 64'h0A00; rd_left[0] = 1;
    m_ar_valid[3] = 1'b1; m_ar_addr[3] = 64'h0D00; rd_left[3] = 1;
    exp_q.push_back('{m: 0, rd: 1'b1, addr: 64'h0A00, data: 64'h10, resp: 2'b00});
    exp_q.push_back('{m: 3, rd: 1'b1, addr: 64'h0D00, data: 64'h13, resp: 2'b01});
    serve_read(0, w);
    serve_read(1, w);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    clear_drives();
    test_reset();
    test_wrap();
    test_single_read();
    test_back_to_back();
    test_rd_wr_same_master();
    test_w_before_aw();
    test_reset_mid_read();
    n_vec++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
